game_sequencer: RTL

Top-level round controller for the whack-a-mole game. It sequences each game through idle, countdown, play and game-over phases. During play it paces mole spawns by issuing spawn pulses to the RNG/LED path, at an interval set by the difficulty level latched at game start. It tracks missed moles, ends the game on timeout or too many misses, and drives the seconds readout and a score-clear pulse for the switches/score path.

---
 rtl/game_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Round controller for the whack-a-mole game: idle -> countdown -> play -> over,
// with millisecond/second timing, difficulty-paced mole spawns and miss tracking.
module game_sequencer #(
  parameter int MS_DIV      = 50000,
  parameter int COUNTDOWN_S = 3,
  parameter int ROUND_S     = 30,
  parameter int SPAWN_MS_L0 = 1000,
  parameter int SPAWN_MS_L1 = 600,
  parameter int SPAWN_MS_L2 = 350,
  parameter int MAX_MISSES  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] level_in,
  input  logic       hit,
  input  logic       miss,
  output logic       spawn_req,
  output logic [1:0] level_out,
  output logic [1:0] phase,
  output logic [6:0] seconds,
  output logic [2:0] misses,
  output logic       clear_score,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  localparam int MS_W = $clog2(MS_DIV);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);
  localparam logic [15:0] SPAWN_LAST_L0 = 16'(SPAWN_MS_L0 - 1);
  localparam logic [15:0] SPAWN_LAST_L1 = 16'(SPAWN_MS_L1 - 1);
  localparam logic [15:0] SPAWN_LAST_L2 = 16'(SPAWN_MS_L2 - 1);

  state_t          state_q, state_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [9:0]      sub_cnt_q, sub_cnt_d;
  logic [15:0]     spawn_cnt_q, spawn_cnt_d;
  logic [6:0]      seconds_q, seconds_d;
  logic [2:0]      misses_q, misses_d;
  logic [1:0]      level_q, level_d;
  logic            spawn_req_q, spawn_req_d;
  logic            clear_q, clear_d;
  logic            game_over_q, game_over_d;

  logic            ms_tick;
  logic            sec_tick;
  logic            spawn_due;
  logic            end_game;
  logic [15:0]     spawn_last;
  logic [2:0]      miss_inc;

  // hit only matters to the score path; sequencing never looks at it.
  logic unused_hit;
  assign unused_hit = hit;

  always_comb begin
    ms_tick   = ((state_q == S_COUNTDOWN) || (state_q == S_PLAY)) && (ms_cnt_q == MS_LAST);
    sec_tick  = ms_tick && (sub_cnt_q == 10'd999);
    case (level_q)
      2'd0:    spawn_last = SPAWN_LAST_L0;
      2'd1:    spawn_last = SPAWN_LAST_L1;
      default: spawn_last = SPAWN_LAST_L2;
    endcase
    spawn_due = ms_tick && (spawn_cnt_q == spawn_last);
    miss_inc  = (misses_q == 3'd7) ? 3'd7 : misses_q + 3'd1;

    state_d     = state_q;
    ms_cnt_d    = ms_tick ? '0 : ms_cnt_q + MS_W'(1);
    sub_cnt_d   = ms_tick ? ((sub_cnt_q == 10'd999) ? 10'd0 : sub_cnt_q + 10'd1) : sub_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    seconds_d   = seconds_q;
    misses_d    = misses_q;
    level_d     = level_q;
    spawn_req_d = 1'b0;
    clear_d     = 1'b0;
    end_game    = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        ms_cnt_d  = '0;
        sub_cnt_d = '0;
        if (start) begin
          state_d   = S_COUNTDOWN;
          seconds_d = 7'(COUNTDOWN_S);
          misses_d  = 3'd0;
          level_d   = (level_in == 2'b11) ? 2'b10 : level_in;
          clear_d   = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (sec_tick) begin
          if (seconds_q == 7'd1) begin
            state_d     = S_PLAY;
            seconds_d   = 7'(ROUND_S);
            spawn_cnt_d = 16'd0;
            spawn_req_d = 1'b1;
          end else begin
            seconds_d = seconds_q - 7'd1;
          end
        end
      end
      S_PLAY: begin
        if (ms_tick) begin
          spawn_cnt_d = spawn_due ? 16'd0 : spawn_cnt_q + 16'd1;
          spawn_req_d = spawn_due;
        end
        if (sec_tick) begin
          seconds_d = seconds_q - 7'd1;
          if (seconds_q == 7'd1) end_game = 1'b1;
        end
        if (miss) begin
          misses_d = miss_inc;
          if (miss_inc == 3'(MAX_MISSES)) end_game = 1'b1;
        end
        // Timeout and final miss share one transition; a spawn due now is dropped.
        if (end_game) begin
          state_d     = S_OVER;
          spawn_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      ms_cnt_d  = '0;
      sub_cnt_d = '0;
    end
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ms_cnt_q    <= '0;
      sub_cnt_q   <= '0;
      spawn_cnt_q <= '0;
      seconds_q   <= '0;
      misses_q    <= '0;
      level_q     <= '0;
      spawn_req_q <= 1'b0;
      clear_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      seconds_q   <= seconds_d;
      misses_q    <= misses_d;
      level_q     <= level_d;
      spawn_req_q <= spawn_req_d;
      clear_q     <= clear_d;
      game_over_q <= game_over_d;
    end
  end

  assign phase       = state_q;
  assign spawn_req   = spawn_req_q;
  assign level_out   = level_q;
  assign seconds     = seconds_q;
  assign misses      = misses_q;
  assign clear_score = clear_q;
  assign game_over   = game_over_q;

endmodule
